cam_match_resolve: RTL and testbench

- Sits directly downstream of the CAM/TCAM BRAM lookup stage.
- Consumes the CAM_NUM-bit multi-hot match vector that stage produces.
- Priority-encodes the vector to the lowest matching entry index, reads the action table at that index, and emits one ACL result per lookup: hit flag, index, fetchinfo and frame type.
- Fully pipelined; accepts one lookup per clock.

---
 rtl/cam_match_resolve.sv | 158 +++++++++++++++
 tb/tb_cam_match_resolve.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_resolve.sv
// CAM match resolver: priority-encodes the match vector, reads the action table, emits one ACL result per lookup.
// Define CAM_MATCH_STAT_EN to add saturating hit/miss counters with a synchronous clear.
module cam_match_resolve #(
    parameter int unsigned CAM_NUM       = 1024,
    parameter int unsigned SEG_WIDTH     = 64,
    parameter int unsigned ACTION_RD_LAT = 2,
    parameter int unsigned ACTION_WIDTH  = 24
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [CAM_NUM-1:0]         i_match_vec,
    input  logic                       i_match_vld,
    output logic [$clog2(CAM_NUM)-1:0] o_action_addrb,
    output logic                       o_action_enb,
    input  logic [ACTION_WIDTH-1:0]    i_action_doutb,
    output logic                       o_result_vld,
    output logic                       o_result_hit,
    output logic [$clog2(CAM_NUM)-1:0] o_result_idx,
    output logic [15:0]                o_acl_fetchinfo,
    output logic [7:0]                 o_acl_frmtype
`ifdef CAM_MATCH_STAT_EN
    ,
    input  logic                       i_stat_clr,
    output logic [31:0]                o_hit_cnt,
    output logic [31:0]                o_miss_cnt
`endif
);

    localparam int unsigned IDX_W  = $clog2(CAM_NUM);
    localparam int unsigned SEG_IW = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;
    localparam int unsigned NSEG   = CAM_NUM / SEG_WIDTH;

    logic [NSEG-1:0]              seg_hit_c;
    logic [NSEG-1:0][SEG_IW-1:0]  seg_idx_c;
    logic                         s1_vld;
    logic [NSEG-1:0]              s1_seg_hit;
    logic [NSEG-1:0][SEG_IW-1:0]  s1_seg_idx;
    logic                         win_hit;
    logic [IDX_W-1:0]             win_idx;
    logic                         s2_vld;
    logic [ACTION_RD_LAT-1:0]             al_vld;
    logic [ACTION_RD_LAT-1:0]             al_hit;
    logic [ACTION_RD_LAT-1:0][IDX_W-1:0]  al_idx;

    // Descending scan: the last assignment is the lowest set bit.
    always_comb begin
        seg_hit_c = '0;
        seg_idx_c = '0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            for (int unsigned b = SEG_WIDTH; b > 0; b--) begin
                if (i_match_vec[s*SEG_WIDTH + b - 1]) begin
                    seg_hit_c[s] = 1'b1;
                    seg_idx_c[s] = SEG_IW'(b - 1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_vld     <= 1'b0;
            s1_seg_hit <= '0;
            s1_seg_idx <= '0;
        end else begin
            s1_vld <= i_match_vld;
            if (i_match_vld) begin
                s1_seg_hit <= seg_hit_c;
                s1_seg_idx <= seg_idx_c;
            end
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int unsigned s = NSEG; s > 0; s--) begin
            if (s1_seg_hit[s-1]) begin
                win_hit = 1'b1;
                win_idx = IDX_W'((s - 1) * SEG_WIDTH) | IDX_W'(s1_seg_idx[s-1]);
            end
        end
    end

    // enb/addrb double as the stage-2 hit/index; a stale addr on miss is masked at the output.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s2_vld         <= 1'b0;
            o_action_enb   <= 1'b0;
            o_action_addrb <= '0;
        end else begin
            s2_vld       <= s1_vld;
            o_action_enb <= s1_vld & win_hit;
            if (s1_vld && win_hit) begin
                o_action_addrb <= win_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            al_vld <= '0;
            al_hit <= '0;
            al_idx <= '0;
        end else begin
            al_vld[0] <= s2_vld;
            al_hit[0] <= o_action_enb;
            al_idx[0] <= o_action_addrb;
            for (int unsigned i = 1; i < ACTION_RD_LAT; i++) begin
                al_vld[i] <= al_vld[i-1];
                al_hit[i] <= al_hit[i-1];
                al_idx[i] <= al_idx[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_result_vld    <= 1'b0;
            o_result_hit    <= 1'b0;
            o_result_idx    <= '0;
            o_acl_fetchinfo <= '0;
            o_acl_frmtype   <= '0;
        end else begin
            o_result_vld <= al_vld[ACTION_RD_LAT-1];
            if (al_vld[ACTION_RD_LAT-1]) begin
                o_result_hit <= al_hit[ACTION_RD_LAT-1];
                if (al_hit[ACTION_RD_LAT-1]) begin
                    o_result_idx    <= al_idx[ACTION_RD_LAT-1];
                    o_acl_fetchinfo <= i_action_doutb[23:8];
                    o_acl_frmtype   <= i_action_doutb[7:0];
                end else begin
                    o_result_idx    <= '0;
                    o_acl_fetchinfo <= '0;
                    o_acl_frmtype   <= '0;
                end
            end
        end
    end

`ifdef CAM_MATCH_STAT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (i_stat_clr) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (o_result_vld) begin
            if (o_result_hit) begin
                if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + 32'd1;
            end else begin
                if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_match_resolve.sv
// Self-checking bench for cam_match_resolve: directed and random lookups against a bit-scan reference model.
module tb_cam_match_resolve;

    localparam int CAM_NUM = 1024;
    localparam int SEG     = 64;
    localparam int LAT     = 2;
    localparam int AW      = 24;
    localparam int IW      = 10;
    localparam int PIPE    = 3 + LAT;
    localparam int MAXN    = 64;
    localparam int OBN     = MAXN + PIPE + 3;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [CAM_NUM-1:0] i_match_vec = '0;
    logic               i_match_vld = 1'b0;
    logic [IW-1:0]      o_action_addrb;
    logic               o_action_enb;
    logic [AW-1:0]      i_action_doutb;
    logic               o_result_vld;
    logic               o_result_hit;
    logic [IW-1:0]      o_result_idx;
    logic [15:0]        o_acl_fetchinfo;
    logic [7:0]         o_acl_frmtype;
`ifdef CAM_MATCH_STAT_EN
    logic               i_stat_clr = 1'b0;
    logic [31:0]        o_hit_cnt;
    logic [31:0]        o_miss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [AW-1:0]      mem [CAM_NUM];
    logic [AW-1:0]      rd [LAT];

    logic [CAM_NUM-1:0] seq_vec [MAXN];
    bit                 seq_vld [MAXN];
    int                 seq_n;

    bit                 ob_vld [OBN];
    bit                 ob_hit [OBN];
    bit                 ob_enb [OBN];
    logic [IW-1:0]      ob_idx [OBN];
    logic [IW-1:0]      ob_addr [OBN];
    logic [15:0]        ob_fi [OBN];
    logic [7:0]         ob_ft [OBN];

    // Last reported result, which the DUT must hold between valid cycles.
    bit                 lh;
    logic [IW-1:0]      li;
    logic [15:0]        lf;
    logic [7:0]         lt;

    cam_match_resolve #(
        .CAM_NUM(CAM_NUM), .SEG_WIDTH(SEG), .ACTION_RD_LAT(LAT), .ACTION_WIDTH(AW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_match_vec(i_match_vec), .i_match_vld(i_match_vld),
        .o_action_addrb(o_action_addrb), .o_action_enb(o_action_enb),
        .i_action_doutb(i_action_doutb),
        .o_result_vld(o_result_vld), .o_result_hit(o_result_hit), .o_result_idx(o_result_idx),
        .o_acl_fetchinfo(o_acl_fetchinfo), .o_acl_frmtype(o_acl_frmtype)
`ifdef CAM_MATCH_STAT_EN
        , .i_stat_clr(i_stat_clr), .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Action RAM with LAT-cycle read latency; returns poison when not enabled.
    always @(posedge i_clk) begin
        rd[0] <= o_action_enb ? mem[o_action_addrb] : 24'hBADBAD;
        for (int i = 1; i < LAT; i++) rd[i] <= rd[i-1];
    end
    assign i_action_doutb = rd[LAT-1];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int lowest_set(input logic [CAM_NUM-1:0] v);
        for (int i = 0; i < CAM_NUM; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [CAM_NUM-1:0] onehot(input int i);
        logic [CAM_NUM-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [CAM_NUM-1:0] rand_vec(input int mode);
        logic [CAM_NUM-1:0] v;
        v = '0;
        case (mode)
            0: ;
            1: v[$urandom_range(CAM_NUM-1, 0)] = 1'b1;
            2: repeat (3) v[$urandom_range(CAM_NUM-1, 0)] = 1'b1;
            default: for (int w = 0; w < CAM_NUM/32; w++) v[w*32 +: 32] = $urandom;
        endcase
        return v;
    endfunction

    task automatic push(input bit vld, input logic [CAM_NUM-1:0] v);
        seq_vld[seq_n] = vld;
        seq_vec[seq_n] = v;
        seq_n++;
    endtask

    // Drives the queued sequence (garbage vectors on idle cycles) and records outputs per cycle.
    task automatic run_seq(input int n);
        for (int c = 0; c < n + PIPE + 3; c++) begin
            @(posedge i_clk); #1;
            i_match_vld = (c < n) ? seq_vld[c] : 1'b0;
            i_match_vec = (c < n && seq_vld[c]) ? seq_vec[c] : rand_vec(3);
            @(negedge i_clk);
            ob_vld[c]  = o_result_vld;
            ob_hit[c]  = o_result_hit;
            ob_idx[c]  = o_result_idx;
            ob_fi[c]   = o_acl_fetchinfo;
            ob_ft[c]   = o_acl_frmtype;
            ob_enb[c]  = o_action_enb;
            ob_addr[c] = o_action_addrb;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_match_vld = 1'b1;
        i_match_vec = '1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_result_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", o_result_vld); end
        checks++; if (o_result_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0b exp=0", o_result_hit); end
        checks++; if (o_result_idx !== '0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", o_result_idx); end
        checks++; if (o_acl_fetchinfo !== '0 || o_acl_frmtype !== '0) begin
            failures++; $display("FAIL reset_action got=%h/%h exp=0/0", o_acl_fetchinfo, o_acl_frmtype); end
        checks++; if (o_action_enb !== 1'b0 || o_action_addrb !== '0) begin
            failures++; $display("FAIL reset_ram_if got enb=%0b addr=%0d exp=0/0", o_action_enb, o_action_addrb); end
`ifdef CAM_MATCH_STAT_EN
        checks++; if (o_hit_cnt !== '0 || o_miss_cnt !== '0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_hit_cnt, o_miss_cnt); end
`endif
        @(posedge i_clk); #1;
        i_match_vld = 1'b0;
        i_match_vec = '0;
        i_rst = 1'b1;
        lh = 1'b0; li = '0; lf = '0; lt = '0;
    endtask

    task automatic test_directed();
        int n;
        seq_n = 0;
        push(1, onehot(100));
        push(0, '0);
        push(1, '0);
        push(0, '0);
        push(1, onehot(1023) | onehot(130) | onehot(64));
        push(1, onehot(0) | onehot(1023));
        push(1, onehot(1023));
        push(0, '0);
        push(0, '0);
        push(1, onehot(0));
        push(1, onehot(63));
        push(1, onehot(64));
        push(1, onehot(511));
        push(1, onehot(512));
        push(1, onehot(1000));
        push(1, '0);
        push(1, onehot(1023));
        n = seq_n;
        run_seq(n);
        for (int k = 0; k < n + PIPE + 3; k++) begin
            int j, e, w, ea;
            bit ev, eenb;
            j = k - PIPE;
            e = k - 2;
            ev = (j >= 0 && j < n) ? seq_vld[j] : 1'b0;
            if (ev) begin
                w = lowest_set(seq_vec[j]);
                lh = (w >= 0);
                li = '0; lf = '0; lt = '0;
                if (lh) begin li = w[IW-1:0]; lf = mem[w][23:8]; lt = mem[w][7:0]; end
            end
            eenb = 1'b0; ea = 0;
            if (e >= 0 && e < n && seq_vld[e]) begin
                ea = lowest_set(seq_vec[e]);
                eenb = (ea >= 0);
            end
            checks++; if (ob_vld[k] !== ev) begin
                failures++; $display("FAIL directed_vld cycle=%0d got=%0b exp=%0b", k, ob_vld[k], ev); end
            checks++; if (ob_hit[k] !== lh || ob_idx[k] !== li || ob_fi[k] !== lf || ob_ft[k] !== lt) begin
                failures++; $display("FAIL directed_result cycle=%0d got hit=%0b idx=%0d fi=%h ft=%h exp hit=%0b idx=%0d fi=%h ft=%h",
                    k, ob_hit[k], ob_idx[k], ob_fi[k], ob_ft[k], lh, li, lf, lt); end
            checks++; if (ob_enb[k] !== eenb) begin
                failures++; $display("FAIL directed_enb cycle=%0d got=%0b exp=%0b", k, ob_enb[k], eenb); end
            if (eenb) begin
                checks++; if (ob_addr[k] !== ea[IW-1:0]) begin
                    failures++; $display("FAIL directed_addr cycle=%0d got=%0d exp=%0d", k, ob_addr[k], ea); end
            end
        end
    endtask

    task automatic test_random();
        int n;
        seq_n = 0;
        for (int i = 0; i < 60; i++) begin
            bit v;
            v = ($urandom_range(3, 0) != 0);
            push(v, rand_vec($urandom_range(3, 0)));
        end
        n = seq_n;
        run_seq(n);
        for (int k = 0; k < n + PIPE + 3; k++) begin
            int j, e, w, ea;
            bit ev, eenb;
            j = k - PIPE;
            e = k - 2;
            ev = (j >= 0 && j < n) ? seq_vld[j] : 1'b0;
            if (ev) begin
                w = lowest_set(seq_vec[j]);
                lh = (w >= 0);
                li = '0; lf = '0; lt = '0;
                if (lh) begin li = w[IW-1:0]; lf = mem[w][23:8]; lt = mem[w][7:0]; end
            end
            eenb = 1'b0; ea = 0;
            if (e >= 0 && e < n && seq_vld[e]) begin
                ea = lowest_set(seq_vec[e]);
                eenb = (ea >= 0);
            end
            checks++; if (ob_vld[k] !== ev) begin
                failures++; $display("FAIL random_vld cycle=%0d got=%0b exp=%0b", k, ob_vld[k], ev); end
            checks++; if (ob_hit[k] !== lh || ob_idx[k] !== li || ob_fi[k] !== lf || ob_ft[k] !== lt) begin
                failures++; $display("FAIL random_result cycle=%0d got hit=%0b idx=%0d fi=%h ft=%h exp hit=%0b idx=%0d fi=%h ft=%h",
                    k, ob_hit[k], ob_idx[k], ob_fi[k], ob_ft[k], lh, li, lf, lt); end
            checks++; if (ob_enb[k] !== eenb) begin
                failures++; $display("FAIL random_enb cycle=%0d got=%0b exp=%0b", k, ob_enb[k], eenb); end
            if (eenb) begin
                checks++; if (ob_addr[k] !== ea[IW-1:0]) begin
                    failures++; $display("FAIL random_addr cycle=%0d got=%0d exp=%0d", k, ob_addr[k], ea); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge i_clk); #1; i_match_vld = 1'b1; i_match_vec = onehot(5);
        @(posedge i_clk); #1; i_match_vec = onehot(700);
        @(posedge i_clk); #1; i_match_vec = onehot(900) | onehot(901);
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++; if (o_result_vld !== 1'b0 || o_result_hit !== 1'b0 || o_result_idx !== '0) begin
            failures++; $display("FAIL midflight_in_reset got vld=%0b hit=%0b idx=%0d exp 0/0/0", o_result_vld, o_result_hit, o_result_idx); end
        @(posedge i_clk); #1; i_match_vld = 1'b0; i_match_vec = '0;
        @(posedge i_clk); #1; i_rst = 1'b1;
        lh = 1'b0; li = '0; lf = '0; lt = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            checks++; if (o_result_vld !== 1'b0 || o_action_enb !== 1'b0) begin
                failures++; $display("FAIL midflight_stale cycle=%0d got vld=%0b enb=%0b exp 0/0", k, o_result_vld, o_action_enb); end
        end
        seq_n = 0;
        push(1, onehot(300) | onehot(777));
        run_seq(1);
        for (int k = 0; k < 1 + PIPE + 3; k++) begin
            bit ev;
            ev = (k == PIPE);
            if (ev) begin lh = 1'b1; li = IW'(300); lf = mem[300][23:8]; lt = mem[300][7:0]; end
            checks++; if (ob_vld[k] !== ev) begin
                failures++; $display("FAIL midflight_new_vld cycle=%0d got=%0b exp=%0b", k, ob_vld[k], ev); end
            checks++; if (ob_hit[k] !== lh || ob_idx[k] !== li || ob_fi[k] !== lf || ob_ft[k] !== lt) begin
                failures++; $display("FAIL midflight_new_result cycle=%0d got hit=%0b idx=%0d fi=%h ft=%h exp hit=%0b idx=%0d fi=%h ft=%h",
                    k, ob_hit[k], ob_idx[k], ob_fi[k], ob_ft[k], lh, li, lf, lt); end
        end
    endtask

`ifdef CAM_MATCH_STAT_EN
    task automatic test_stat();
        int hits, misses;
        @(posedge i_clk); #1; i_stat_clr = 1'b1;
        @(posedge i_clk); #1; i_stat_clr = 1'b0;
        seq_n = 0; hits = 0; misses = 0;
        while (hits < 10 || misses < 4) begin
            if (misses < 4 && (hits == 10 || $urandom_range(2, 0) == 0)) begin
                push(1, '0); misses++;
            end else begin
                push(1, rand_vec(2)); hits++;
            end
        end
        run_seq(seq_n);
        checks++; if (o_hit_cnt !== 32'd10 || o_miss_cnt !== 32'd4) begin
            failures++; $display("FAIL stat_counts got=%0d/%0d exp=10/4", o_hit_cnt, o_miss_cnt); end
        @(posedge i_clk); #1; i_match_vld = 1'b1; i_match_vec = onehot(7);
        @(posedge i_clk); #1; i_match_vld = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        checks++; if (o_result_vld !== 1'b1 || o_result_hit !== 1'b1) begin
            failures++; $display("FAIL stat_clr_setup got vld=%0b hit=%0b exp 1/1", o_result_vld, o_result_hit); end
        i_stat_clr = 1'b1;
        @(posedge i_clk); #1; i_stat_clr = 1'b0;
        @(negedge i_clk);
        checks++; if (o_hit_cnt !== '0 || o_miss_cnt !== '0) begin
            failures++; $display("FAIL stat_clr_priority got=%0d/%0d exp=0/0", o_hit_cnt, o_miss_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < CAM_NUM; i++) mem[i] = AW'($urandom);
        mem[100] = 24'h12345A;
        test_reset();
        test_directed();
        test_random();
        test_reset_midflight();
`ifdef CAM_MATCH_STAT_EN
        test_stat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
